fetch_unit: RTL and testbench

//  Instruction fetch stage, directly upstream of the controller/decode stage.

---
 rtl/dmips_pkg.sv | 29 ++
 rtl/fetch_unit_if.sv | 21 ++
 rtl/fetch_next_pc.sv | 33 +++
 rtl/fetch_unit.sv | 89 ++++++++
 tb/tb_fetch_unit.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/dmips_pkg.sv
// Shared definitions for the fetch stage: reset constants, FSM encoding and
// instruction field positions used by fetch and decode.
package dmips_pkg;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_NOP      = 32'h0000_0000;

    // Instruction field ranges
    localparam int OP_MSB     = 31;
    localparam int OP_LSB     = 26;
    localparam int FUNCT_MSB  = 5;
    localparam int FUNCT_LSB  = 0;
    localparam int IMM_MSB    = 15;
    localparam int IMM_LSB    = 0;
    localparam int TARGET_MSB = 25;
    localparam int TARGET_LSB = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_VALID = 2'd2
    } fetch_state_e;

    // Sign-extended, word-scaled branch offset taken from the immediate field
    function automatic logic [31:0] branch_offset(input logic [31:0] instr);
        return {{14{instr[IMM_MSB]}}, instr[IMM_MSB:IMM_LSB], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request bus: fetch unit is master, imem is slave.
interface fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_next_pc.sv
// Combinational next-PC select: jump > branch > sequential.
module fetch_next_pc
    import dmips_pkg::*;
(
    input  logic [31:0] pc_plus4,
    input  logic [31:0] instr,
    input  logic        branch_taken,
    input  logic        jump,
    output logic [31:0] next_pc
);

    logic [31:0] jump_target;
    logic [31:0] branch_target;
    logic        unused_op_bits;

    // The opcode bits play no part in target computation
    assign unused_op_bits = ^instr[OP_MSB:OP_LSB];

    assign jump_target   = {pc_plus4[31:28], instr[TARGET_MSB:TARGET_LSB], 2'b00};
    // Plain 32-bit add: wraps silently past 0xFFFF_FFFC
    assign branch_target = pc_plus4 + branch_offset(instr);

    // Priority select of the next fetch address
    always_comb begin
        next_pc = pc_plus4;
        if (jump) begin
            next_pc = jump_target;
        end else if (branch_taken) begin
            next_pc = branch_target;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC and instruction register, a three-state
// request FSM towards imem and the next-PC selection on accept.
module fetch_unit
    import dmips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter logic [31:0] NOP      = DEFAULT_NOP
) (
    input  logic                clk,
    input  logic                reset,
    fetch_unit_if.master        imem,
    output logic [31:0]         instr,
    output logic                instr_valid,
    output logic [31:0]         pc_plus4,
    input  logic                instr_accept,
    input  logic                branch_taken,
    input  logic                jump
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  instr_q, instr_d;
    logic [31:0]  pc_plus4_q, pc_plus4_d;
    logic [31:0]  next_pc;
    logic         req;

    fetch_next_pc u_next_pc (
        .pc_plus4     (pc_plus4_q),
        .instr        (instr_q),
        .branch_taken (branch_taken),
        .jump         (jump),
        .next_pc      (next_pc)
    );

    // State and datapath registers; reset discards any held instruction
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            pc_q       <= RESET_PC;
            instr_q    <= NOP;
            pc_plus4_q <= RESET_PC + 32'd4;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            pc_plus4_q <= pc_plus4_d;
        end
    end

    // Next-state logic: request until ready, then hold until accepted
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        instr_d     = instr_q;
        pc_plus4_d  = pc_plus4_q;
        req         = 1'b0;
        instr_valid = 1'b0;
        case (state_q)
            ST_IDLE: begin
                state_d = ST_REQ;
            end
            ST_REQ: begin
                req = 1'b1;
                if (imem.imem_ready) begin
                    instr_d    = imem.imem_rdata;
                    pc_plus4_d = pc_q + 32'd4;
                    state_d    = ST_VALID;
                end
            end
            ST_VALID: begin
                instr_valid = 1'b1;
                if (instr_accept) begin
                    pc_d    = next_pc;
                    state_d = ST_REQ;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign imem.imem_req  = req;
    assign imem.imem_addr = pc_q;
    // Present NOP whenever nothing valid is held
    assign instr          = instr_valid ? instr_q : NOP;
    assign pc_plus4       = pc_plus4_q;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    logic        clk;
    logic        reset;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] pc_plus4;
    logic        instr_accept;
    logic        branch_taken;
    logic        jump;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    logic [31:0] exp_pc;

    fetch_unit_if bus ();

    fetch_unit dut (
        .clk          (clk),
        .reset        (reset),
        .imem         (bus),
        .instr        (instr),
        .instr_valid  (instr_valid),
        .pc_plus4     (pc_plus4),
        .instr_accept (instr_accept),
        .branch_taken (branch_taken),
        .jump         (jump)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference: next fetch address from the architectural rules
    function automatic logic [31:0] ref_next(input logic [31:0] pc, input logic [31:0] w,
                                             input logic br, input logic jp);
        logic [31:0] seq;
        int          off;
        logic [15:0] imm;
        seq = pc + 32'd4;
        imm = w[15:0];
        off = int'($signed(imm)) * 4;
        if (jp) return (seq & 32'hF000_0000) | ((w & 32'h03FF_FFFF) << 2);
        if (br) return seq + 32'(off);
        return seq;
    endfunction

    // One full fetch/accept transaction, entered and left at a negedge in REQ
    task automatic fetch_one(input logic [31:0] word, input int wait_n, input int hold_n,
                             input logic br, input logic jp);
        logic [31:0] exp_p4;
        exp_p4 = exp_pc + 32'd4;
        checks++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== exp_pc) begin
            errors++;
            $display("FAIL req_start: req=%b addr=%h, want req=1 addr=%h", bus.imem_req, bus.imem_addr, exp_pc);
        end
        for (int i = 0; i < wait_n; i++) begin
            bus.imem_ready = 1'b0;
            bus.imem_rdata = $urandom;
            instr_accept   = 1'($urandom_range(0, 1));
            branch_taken   = 1'($urandom_range(0, 1));
            jump           = 1'($urandom_range(0, 1));
            @(negedge clk);
            checks++;
            if (bus.imem_req !== 1'b1 || bus.imem_addr !== exp_pc || instr_valid !== 1'b0) begin
                errors++;
                $display("FAIL req_stall: req=%b addr=%h valid=%b, want 1 %h 0", bus.imem_req, bus.imem_addr, instr_valid, exp_pc);
            end
        end
        bus.imem_ready = 1'b1;
        bus.imem_rdata = word;
        instr_accept   = 1'($urandom_range(0, 1));
        branch_taken   = 1'($urandom_range(0, 1));
        jump           = 1'($urandom_range(0, 1));
        @(negedge clk);
        checks++;
        if (instr_valid !== 1'b1 || instr !== word || pc_plus4 !== exp_p4 || bus.imem_req !== 1'b0) begin
            errors++;
            $display("FAIL capture: valid=%b instr=%h pc4=%h req=%b, want 1 %h %h 0", instr_valid, instr, pc_plus4, bus.imem_req, word, exp_p4);
        end
        for (int i = 0; i < hold_n; i++) begin
            instr_accept   = 1'b0;
            branch_taken   = 1'($urandom_range(0, 1));
            jump           = 1'($urandom_range(0, 1));
            bus.imem_ready = 1'($urandom_range(0, 1));
            bus.imem_rdata = $urandom;
            @(negedge clk);
            checks++;
            if (instr_valid !== 1'b1 || instr !== word || pc_plus4 !== exp_p4 || bus.imem_req !== 1'b0) begin
                errors++;
                $display("FAIL hold: valid=%b instr=%h pc4=%h req=%b, want 1 %h %h 0", instr_valid, instr, pc_plus4, bus.imem_req, word, exp_p4);
            end
        end
        instr_accept   = 1'b1;
        branch_taken   = br;
        jump           = jp;
        bus.imem_ready = 1'b0;
        @(negedge clk);
        instr_accept = 1'b0;
        branch_taken = 1'b0;
        jump         = 1'b0;
        exp_pc = ref_next(exp_pc, word, br, jp);
        checks++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== exp_pc || instr_valid !== 1'b0 || instr !== 32'h0) begin
            errors++;
            $display("FAIL accept: req=%b addr=%h valid=%b instr=%h, want 1 %h 0 0", bus.imem_req, bus.imem_addr, instr_valid, instr, exp_pc);
        end
        $display("txn word=%h br=%b jp=%b wait=%0d hold=%0d -> next_pc=%h", word, br, jp, wait_n, hold_n, bus.imem_addr);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.imem_ready = 1'b0;
        bus.imem_rdata = 32'h0;
        instr_accept = 1'b0;
        branch_taken = 1'b0;
        jump = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.imem_req !== 1'b0 || instr_valid !== 1'b0 || instr !== 32'h0 || pc_plus4 !== 32'h4) begin
            errors++;
            $display("FAIL reset_state: req=%b valid=%b instr=%h pc4=%h, want 0 0 0 4", bus.imem_req, instr_valid, instr, pc_plus4);
        end
        reset = 1'b0;
        @(negedge clk);
        exp_pc = 32'h0;
        checks++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin
            errors++;
            $display("FAIL first_req: req=%b addr=%h, want 1 00000000", bus.imem_req, bus.imem_addr);
        end
    endtask

    typedef struct {
        logic [31:0] word;
        int          wait_n;
        int          hold_n;
        logic        br;
        logic        jp;
        logic [31:0] want_addr;
    } step_t;

    task automatic test_directed();
        step_t steps[9];
        steps[0] = '{32'h0022_1820, 0, 0, 1'b0, 1'b0, 32'h0000_0004};
        steps[1] = '{32'h0043_2020, 0, 0, 1'b0, 1'b0, 32'h0000_0008};
        steps[2] = '{32'h1022_0005, 0, 0, 1'b1, 1'b0, 32'h0000_0020};
        steps[3] = '{32'h0800_0002, 0, 0, 1'b0, 1'b1, 32'h0000_0008};
        steps[4] = '{32'h1022_0005, 3, 3, 1'b0, 1'b0, 32'h0000_000C};
        steps[5] = '{32'h0022_1820, 0, 0, 1'b0, 1'b0, 32'h0000_0010};
        steps[6] = '{32'h0800_000a, 0, 0, 1'b0, 1'b1, 32'h0000_0028};
        steps[7] = '{32'h0800_000a, 0, 0, 1'b1, 1'b1, 32'h0000_0028};
        steps[8] = '{32'h0800_0005, 1, 2, 1'b0, 1'b1, 32'h0000_0014};
        foreach (steps[i]) begin
            fetch_one(steps[i].word, steps[i].wait_n, steps[i].hold_n, steps[i].br, steps[i].jp);
            checks++;
            if (bus.imem_addr !== steps[i].want_addr) begin
                errors++;
                $display("FAIL directed_addr[%0d]: got %h want %h", i, bus.imem_addr, steps[i].want_addr);
            end
        end
    endtask

    task automatic test_reset_midflight();
        // In REQ at 0x14: pulse reset between edges
        #2 reset = 1'b1;
        #1;
        checks++;
        if (bus.imem_req !== 1'b0 || instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_in_req: req=%b valid=%b, want 0 0", bus.imem_req, instr_valid);
        end
        #1 reset = 1'b0;
        @(negedge clk);
        exp_pc = 32'h0;
        checks++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin
            errors++;
            $display("FAIL restart_after_req_reset: req=%b addr=%h, want 1 0", bus.imem_req, bus.imem_addr);
        end
        // Move into VALID, then reset again
        bus.imem_ready = 1'b1;
        bus.imem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        bus.imem_ready = 1'b0;
        #2 reset = 1'b1;
        #1;
        checks++;
        if (bus.imem_req !== 1'b0 || instr_valid !== 1'b0 || instr !== 32'h0) begin
            errors++;
            $display("FAIL reset_in_valid: req=%b valid=%b instr=%h, want 0 0 0", bus.imem_req, instr_valid, instr);
        end
        #1 reset = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin
            errors++;
            $display("FAIL restart_after_valid_reset: req=%b addr=%h, want 1 0", bus.imem_req, bus.imem_addr);
        end
    endtask

    task automatic test_wrap();
        // beq with offset -8 from pc_plus4=4 lands on 0xFFFFFFFC
        fetch_one(32'h1000_FFFE, 0, 0, 1'b1, 1'b0);
        checks++;
        if (bus.imem_addr !== 32'hFFFF_FFFC) begin
            errors++;
            $display("FAIL wrap_target: got %h want fffffffc", bus.imem_addr);
        end
        fetch_one(32'h0022_1820, 0, 1, 1'b0, 1'b0);
        checks++;
        if (bus.imem_addr !== 32'h0) begin
            errors++;
            $display("FAIL wrap_seq: got %h want 00000000", bus.imem_addr);
        end
    endtask

    task automatic test_back_to_back();
        int start;
        start = cyc;
        for (int i = 0; i < 6; i++) begin
            fetch_one($urandom, 0, 0, 1'b0, 1'b0);
        end
        checks++;
        if (cyc - start !== 12) begin
            errors++;
            $display("FAIL b2b_rate: %0d cycles for 6 instrs, want 12", cyc - start);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            fetch_one($urandom, $urandom_range(0, 3), $urandom_range(0, 3),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_reset_midflight();
        test_wrap();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
